// File: rtl/router_pkg.sv
// Shared definitions for the router input-port stages: output-port indices,
// header field offsets and the one-hot output-port request type.
package router_pkg;

  // Output-port indices; these are also the bit positions inside a request
  localparam int PORT_N    = 0;
  localparam int PORT_S    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_PE   = 4;
  localparam int NUM_PORTS = 5;

  // One-hot output-port request, bit order {PE, W, E, S, N}
  typedef logic [NUM_PORTS-1:0] req_t;

  // hy occupies the lowest HOP_W bits of the header
  function automatic int HY_LSB(input int hop_w);
    return hop_w * 0;
  endfunction

  // hx sits directly above hy
  function automatic int HX_LSB(input int hop_w);
    return hop_w;
  endfunction

  // Y direction bit: 0 = +Y (north), 1 = -Y (south)
  function automatic int DY_BIT(input int hop_w);
    return 2 * hop_w;
  endfunction

  // X direction bit: 0 = +X (east), 1 = -X (west)
  function automatic int DX_BIT(input int hop_w);
    return 2 * hop_w + 1;
  endfunction

endpackage

// File: rtl/route_dor_calc.sv
// Combinational dimension-order route decode for one header flit.
// Picks the first non-zero hop field in the selected order, requests the
// matching output port and consumes one hop from that field only.
module route_dor_calc
  import router_pkg::*;
#(
  parameter int HOP_W = 4
) (
  input  logic             yx_mode,
  input  logic [HOP_W-1:0] hx,
  input  logic [HOP_W-1:0] hy,
  input  logic             dx,
  input  logic             dy,
  output req_t             req,
  output logic [HOP_W-1:0] hx_next,
  output logic [HOP_W-1:0] hy_next,
  output logic             illegal
);

  logic hx_nz;
  logic hy_nz;
  logic hx_bad;
  logic hy_bad;

  assign hx_nz = (hx != '0);
  assign hy_nz = (hy != '0);

  // A thermometer code plus one is a power of two, so it shares no set bits
  assign hx_bad = ((hx & (hx + HOP_W'(1))) != '0);
  assign hy_bad = ((hy & (hy + HOP_W'(1))) != '0);
  assign illegal = hx_bad | hy_bad;

  // Route on the first dimension still holding hops; routing uses only the zero test
  always_comb begin
    req     = '0;
    hx_next = hx;
    hy_next = hy;
    if (!yx_mode) begin
      if (hx_nz) begin
        if (dx) req[PORT_W] = 1'b1;
        else    req[PORT_E] = 1'b1;
        hx_next = hx >> 1;
      end else if (hy_nz) begin
        if (dy) req[PORT_S] = 1'b1;
        else    req[PORT_N] = 1'b1;
        hy_next = hy >> 1;
      end else begin
        req[PORT_PE] = 1'b1;
      end
    end else begin
      if (hy_nz) begin
        if (dy) req[PORT_S] = 1'b1;
        else    req[PORT_N] = 1'b1;
        hy_next = hy >> 1;
      end else if (hx_nz) begin
        if (dx) req[PORT_W] = 1'b1;
        else    req[PORT_E] = 1'b1;
        hx_next = hx >> 1;
      end else begin
        req[PORT_PE] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_dor_buf.sv
// Route-computation stage with output FIFO. Each accepted header is decoded
// into a one-hot port request, its consumed hop field is shifted, and the
// result is queued until the switch allocator pops it.
module route_dor_buf
  import router_pkg::*;
#(
  parameter int HOP_W  = 4,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              yx_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_req,
  output logic              hop_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int HY_L  = HY_LSB(HOP_W);
  localparam int HX_L  = HX_LSB(HOP_W);
  localparam int DY_B  = DY_BIT(HOP_W);
  localparam int DX_B  = DX_BIT(HOP_W);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  req_t              req_q  [DEPTH];
  req_t              req_d  [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              hop_err_q, hop_err_d;

  logic              push;
  logic              pop;
  req_t              calc_req;
  logic [HOP_W-1:0]  hx_next;
  logic [HOP_W-1:0]  hy_next;
  logic              calc_illegal;
  logic [DATA_W-1:0] flit_next;

  route_dor_calc #(
    .HOP_W (HOP_W)
  ) u_calc (
    .yx_mode (yx_mode),
    .hx      (in_data[HX_L +: HOP_W]),
    .hy      (in_data[HY_L +: HOP_W]),
    .dx      (in_data[DX_B]),
    .dy      (in_data[DY_B]),
    .req     (calc_req),
    .hx_next (hx_next),
    .hy_next (hy_next),
    .illegal (calc_illegal)
  );

  // Handshake status depends on the occupancy count alone, never on out_ready
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = data_q[rd_ptr_q];
  assign out_req  = req_q[rd_ptr_q];
  assign hop_err  = hop_err_q;

  // Rebuild the flit with updated hop fields; the untouched field reloads itself
  always_comb begin
    flit_next                 = in_data;
    flit_next[HX_L +: HOP_W]  = hx_next;
    flit_next[HY_L +: HOP_W]  = hy_next;
  end

  // FIFO next state: write on push, advance pointers, track occupancy and sticky error
  always_comb begin
    data_d    = data_q;
    req_d     = req_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    hop_err_d = hop_err_q | (push & calc_illegal);
    if (push) begin
      data_d[wr_ptr_q] = flit_next;
      req_d[wr_ptr_q]  = calc_req;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset also clears storage so the head reads as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        req_q[i]  <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hop_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      req_q     <= req_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hop_err_q <= hop_err_d;
    end
  end

endmodule

// File: tb/tb_route_dor_buf.sv
// Self-checking bench for route_dor_buf: directed routing cases, full-FIFO
// handshake, back-to-back streaming, randomized traffic and mid-run reset,
// all checked against a queue-based reference model.
module tb_route_dor_buf;

  localparam int HOP_W  = 4;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              yx_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_req;
  logic              hop_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [4:0]        req;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_err;

  route_dor_buf #(
    .HOP_W  (HOP_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .yx_mode   (yx_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_req   (out_req),
    .hop_err   (hop_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // A hop count is legal when it is one of the thermometer values 0,1,3,7,...
  function automatic bit is_therm(input int v);
    for (int k = 0; k <= HOP_W; k++)
      if (v == (1 << k) - 1) return 1'b1;
    return 1'b0;
  endfunction

  // Reference route: travel the first dimension with hops left, one hop fewer
  function automatic void model_route(input logic [DATA_W-1:0] f, input logic yx,
                                      output logic [4:0] req, output logic [DATA_W-1:0] nf,
                                      output bit bad);
    int  hx, hy;
    bit  dx, dy;
    hx  = int'(f[7:4]);
    hy  = int'(f[3:0]);
    dy  = f[8];
    dx  = f[9];
    nf  = f;
    bad = !(is_therm(hx) && is_therm(hy));
    if (!yx && hx > 0) begin
      req = dx ? 5'b01000 : 5'b00100; nf[7:4] = 4'(hx / 2);
    end else if (hy > 0) begin
      req = dy ? 5'b00010 : 5'b00001; nf[3:0] = 4'(hy / 2);
    end else if (hx > 0) begin
      req = dx ? 5'b01000 : 5'b00100; nf[7:4] = 4'(hx / 2);
    end else begin
      req = 5'b10000;
    end
  endfunction

  function automatic logic [3:0] rand_hop();
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return 4'((1 << $urandom_range(0, HOP_W)) - 1);
  endfunction

  function automatic logic [DATA_W-1:0] rand_flit();
    logic [DATA_W-1:0] f;
    f       = {$urandom, $urandom};
    f[3:0]  = rand_hop();
    f[7:4]  = rand_hop();
    return f;
  endfunction

  // Advance one clock and update the model with whatever the inputs imply
  task automatic cycle();
    bit   push, pop, bad;
    ent_t e;
    e    = '0;
    bad  = 1'b0;
    push = !reset && in_valid && (mq.size() < DEPTH);
    pop  = !reset && out_ready && (mq.size() > 0);
    if (push) model_route(in_data, yx_mode, e.req, e.data, bad);
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        if (bad) m_err = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic yx, input logic rdy);
    in_valid  = v;
    in_data   = d;
    yx_mode   = yx;
    out_ready = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++; if (out_req !== 5'b0) begin tests_failed++; $display("[TB] FAIL reset_out_req got %b want 00000", out_req); end
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
    tests_run++; if (hop_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hop_err got %b want 0", hop_err); end
  endtask

  task automatic test_directed();
    logic [DATA_W-1:0] d;
    // XY east
    d = {$urandom, $urandom}; d[9:0] = 10'b0_0_0011_0001;
    applyStimulus(1'b1, d, 1'b0, 1'b0); cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL xy_valid got %b want 1", out_valid); end
    tests_run++; if (out_req !== 5'b00100) begin tests_failed++; $display("[TB] FAIL xy_req got %b want 00100", out_req); end
    tests_run++; if (out_data !== {d[63:8], 8'b0001_0001}) begin tests_failed++; $display("[TB] FAIL xy_data got %h want %h", out_data, {d[63:8], 8'b0001_0001}); end
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL xy_pop got %b want 0", out_valid); end
    // YX south
    d = {$urandom, $urandom}; d[9:0] = 10'b1_1_0001_0111;
    applyStimulus(1'b1, d, 1'b1, 1'b0); cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tests_run++; if (out_req !== 5'b00010) begin tests_failed++; $display("[TB] FAIL yx_req got %b want 00010", out_req); end
    tests_run++; if (out_data !== {d[63:8], 8'b0001_0011}) begin tests_failed++; $display("[TB] FAIL yx_data got %h want %h", out_data, {d[63:8], 8'b0001_0011}); end
    cycle();
    // Destination reached
    d = {$urandom, $urandom}; d[7:0] = 8'h00;
    applyStimulus(1'b1, d, 1'($urandom), 1'b0); cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tests_run++; if (out_req !== 5'b10000) begin tests_failed++; $display("[TB] FAIL pe_req got %b want 10000", out_req); end
    tests_run++; if (out_data !== d) begin tests_failed++; $display("[TB] FAIL pe_data got %h want %h", out_data, d); end
    cycle();
    // Non-thermometer hx, still routed west
    tests_run++; if (hop_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL pre_err got %b want 0", hop_err); end
    d = {$urandom, $urandom}; d[9:0] = 10'b1_0_0101_0000;
    applyStimulus(1'b1, d, 1'b0, 1'b0); cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tests_run++; if (hop_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_err got %b want 1", hop_err); end
    tests_run++; if (out_req !== 5'b01000) begin tests_failed++; $display("[TB] FAIL bad_req got %b want 01000", out_req); end
    tests_run++; if (out_data[7:0] !== 8'b0010_0000) begin tests_failed++; $display("[TB] FAIL bad_data got %h want 20", out_data[7:0]); end
    for (int i = 0; i < 3; i++) cycle();
    tests_run++; if (hop_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL sticky_err got %b want 1", hop_err); end
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] f [3];
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin f[i] = rand_flit(); f[i][7:0] = 8'h00; end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, f[i], 1'b0, 1'b0);
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_ready%0d got %b want 1", i, in_ready); end
      cycle();
    end
    applyStimulus(1'b1, f[2], 1'b0, 1'b0);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_ready got %b want 0", in_ready); end
    cycle();
    out_ready = 1'b1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL popfull_ready got %b want 0", in_ready); end
    cycle();
    tests_run++; if (out_data !== f[1]) begin tests_failed++; $display("[TB] FAIL pop_only_head got %h want %h", out_data, f[1]); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL after_pop_ready got %b want 1", in_ready); end
    cycle();
    tests_run++; if (out_data !== f[2] || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL pushpop_head got %h/%b want %h/1", out_data, out_valid, f[2]); end
    tests_run++; if (mq.size() != 1 || mq[0].data !== f[2]) begin tests_failed++; $display("[TB] FAIL model_order got %0d entries want 1", mq.size()); end
    in_valid = 1'b0; cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, rand_flit(), 1'($urandom), 1'b1);
      cycle();
      tests_run++;
      if (out_valid !== 1'b1 || mq.size() != 1 || out_data !== mq[0].data || out_req !== mq[0].req) begin
        tests_failed++; $display("[TB] FAIL b2b%0d got %b/%h/%b want 1/%h/%b", i, out_valid, out_data, out_req, mq[0].data, mq[0].req);
      end
    end
    in_valid = 1'b0; cycle();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), rand_flit(), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      tests_run++; if (in_ready !== (mq.size() < DEPTH)) begin tests_failed++; $display("[TB] FAIL rnd_ready%0d got %b want %b", i, in_ready, mq.size() < DEPTH); end
      cycle();
      tests_run++; if (out_valid !== (mq.size() > 0)) begin tests_failed++; $display("[TB] FAIL rnd_valid%0d got %b want %b", i, out_valid, mq.size() > 0); end
      tests_run++; if (hop_err !== m_err) begin tests_failed++; $display("[TB] FAIL rnd_err%0d got %b want %b", i, hop_err, m_err); end
      if (mq.size() > 0) begin
        tests_run++;
        if (out_data !== mq[0].data || out_req !== mq[0].req) begin
          tests_failed++; $display("[TB] FAIL rnd_head%0d got %h/%b want %h/%b", i, out_data, out_req, mq[0].data, mq[0].req);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    d = rand_flit(); d[7:4] = 4'b0110;
    applyStimulus(1'b1, d, 1'b0, 1'b0); cycle();
    applyStimulus(1'b1, rand_flit(), 1'b0, 1'b0); cycle();
    tests_run++; if (hop_err !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL pre_mid got %b/%b want 1/0", hop_err, in_ready); end
    applyStimulus(1'b1, rand_flit(), 1'b0, 1'b1);
    reset = 1'b1; cycle(); reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_valid got %b want 0", out_valid); end
    tests_run++; if (out_req !== 5'b0) begin tests_failed++; $display("[TB] FAIL mid_req got %b want 0", out_req); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_ready got %b want 1", in_ready); end
    tests_run++; if (hop_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_err got %b want 0", hop_err); end
  endtask

  initial begin
    m_err = 1'b0;
    test_reset();
    test_directed();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
